serv_uart_rx_mux: RTL and testbench
===================================

# serv_uart_rx_mux

Receive side of the multi-core serial output path. Takes the serial TX lines of `NUM` SERV SoC instances, picks one channel with a switch input, and decodes it as UART 8N1. Decoded bytes go out on a valid/ready byte stream for on-board logging or a host bridge. It replaces blind pin muxing with a real byte-level receiver that survives channel switches mid-frame.

## Interface
Parameters:
- `NUM`, 6: number of serial input channels (1..8).
- `CLKS_PER_BIT`, 139: `i_clk` cycles per UART bit; minimum 4.

Ports:
- `i_clk`, input, 1: single clock; all logic is on the rising edge.
- `i_rst`, input, 1: asynchronous, active-high reset.
- `i_q`, input, `NUM`: raw serial lines, idle high, asynchronous to `i_clk`.
- `i_sel`, input, 3: channel select; values ≥ `NUM` select channel 0.
- `o_data`, output, 8: received byte, valid while `o_valid`=1.
- `o_valid`, output, 1: byte available.
- `i_ready`, input, 1: consumer accepts the byte when `o_valid && i_ready`.
- `o_ferr`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `o_overrun`, output, 1: one-cycle pulse when a completed byte is dropped because the buffer is full.

## Operation
- `i_sel` is registered. The selected `i_q` bit goes through a 2-flop synchronizer (reset value 1) before the FSM sees it.
- Bit counter: `$clog2(CLKS_PER_BIT)` bits. Bit index: 3 bits.
- FSM states:
  - IDLE: when `armed` and the synced line is low, go to START and load the counter with `CLKS_PER_BIT/2 - 1`.
  - START: at counter 0, resample the line. If low, go to DATA and load `CLKS_PER_BIT-1`. If high, treat it as a glitch and return to IDLE.
  - DATA: sample at each counter expiry and shift LSB first. After bit 7, go to STOP.
  - STOP: sample at counter expiry.
    - Line high: push the byte.
    - Line low: pulse `o_ferr`, discard the byte, clear `armed`.
    - In both cases return to IDLE.
- `armed` is set whenever the synced line is high in IDLE. It blocks false starts after a framing error or a channel switch.
- Channel switch: if the registered `i_sel` changes while the FSM is not in IDLE, abort to IDLE, clear `armed`, and discard the partial byte. No error pulse. The synchronizer is not flushed.
- Push into a full buffer: pulse `o_overrun` and drop the new byte. Stored bytes are kept.
- A push and a pop in the same cycle on a full buffer is legal: the pop frees the slot, so no overrun.

## Timing
- Reset values:
  - `o_data`=0, `o_valid`=0, `o_ferr`=0, `o_overrun`=0.
  - FSM in IDLE, `armed`=0, buffer empty, sync flops = 1.
- Let t0 be the first cycle the synced line is low in IDLE. t0 is 2 cycles after the raw edge, plus 1 cycle if the select register was just updated.
  - Start check at t0 + `CLKS_PER_BIT/2`.
  - Data bit k is sampled at t0 + `CLKS_PER_BIT/2` + (k+1)·`CLKS_PER_BIT`.
  - Stop bit is sampled at t0 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`.
- `o_valid` rises, and `o_ferr`/`o_overrun` pulse, on the cycle after the stop sample.
- `o_valid` stays asserted and `o_data` stays stable until accepted. The next buffered byte appears on the cycle after the handshake.
- Back-to-back frames are accepted with no idle time beyond the stop bit.

## Configuration
- `SERV_UART_RX_FIFO_EN` defined: 4-entry circular FIFO (2-bit pointers plus a wrap bit). Overrun fires only when all 4 entries are full.
- Not defined: single holding register. Overrun fires when a byte completes while `o_valid`=1 and the byte is not being accepted that cycle.

## Test plan
Use `CLKS_PER_BIT`=8 and `NUM`=6 for all scenarios.
- Reset then idle: `i_q`=all 1, `i_sel`=2, `i_ready`=1 → `o_valid` stays 0 and no pulses on `o_ferr` or `o_overrun`.
- Single byte: send 0xA5 on channel 2 with `i_sel`=2, `i_ready`=1 → `o_data`=0xA5 with `o_valid` high for 1 cycle, exactly t0+4+72+1 cycles after the synced edge.
- Framing error: send 0x3C on channel 2 with the stop bit low → `o_ferr` pulses once and no byte is output. 0x55 sent after the line has been high for 1 bit time is received correctly.
- Channel switch mid-frame: start 0xFF on channel 1, switch `i_sel` from 1 to 4 during bit 3, then send 0x12 on channel 4 → only 0x12 is output, with no error pulse.
- Overrun: hold `i_ready`=0 and send 0x01..0x05 back-to-back.
  - FIFO build: 0x01..0x04 are retained and `o_overrun` pulses once, on 0x05.
  - Register build: 0x01 is retained and `o_overrun` pulses 4 times.
- Glitch and out-of-range select: a 2-cycle low pulse on the selected line gives no byte. With `i_sel`=7, 0x81 sent on channel 0 is received.

Source files
------------

// File: rtl/serv_uart_rx_mux.sv
// rtl/serv_uart_rx_mux.sv - selectable multi-channel UART 8N1 receiver with byte stream output
// Define SERV_UART_RX_FIFO_EN for a 4-entry output FIFO; otherwise a single holding register.
module serv_uart_rx_mux #(
    parameter int NUM          = 6,
    parameter int CLKS_PER_BIT = 139
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [NUM-1:0] i_q,
    input  logic [2:0]     i_sel,
    output logic [7:0]     o_data,
    output logic           o_valid,
    input  logic           i_ready,
    output logic           o_ferr,
    output logic           o_overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [2:0]    sel_q;
    logic          sel_bit;
    logic [1:0]    sync;
    logic          line;
    logic          sel_chg;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    sh, sh_n;
    logic          armed, armed_n;
    logic          push;
    logic          ferr_set;
    logic          accept;

    // Out-of-range selects fall through to channel 0.
    always_comb begin
        sel_bit = i_q[0];
        for (int i = 0; i < NUM; i++) begin
            if (sel_q == 3'(i)) sel_bit = i_q[i];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sel_q <= 3'd0;
            sync  <= 2'b11;
        end else begin
            sel_q <= i_sel;
            sync  <= {sync[0], sel_bit};
        end
    end

    assign line    = sync[1];
    assign sel_chg = (i_sel != sel_q);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= 3'd0;
            sh    <= 8'd0;
            armed <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            sh    <= sh_n;
            armed <= armed_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        sh_n     = sh;
        armed_n  = armed;
        push     = 1'b0;
        ferr_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (line) begin
                    armed_n = 1'b1;
                end else if (armed) begin
                    state_n = S_START;
                    cnt_n   = HALF_LOAD;
                end
            end
            S_START: begin
                if (cnt == '0) begin
                    if (!line) begin
                        state_n = S_DATA;
                        cnt_n   = FULL_LOAD;
                        idx_n   = 3'd0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_DATA: begin
                if (cnt == '0) begin
                    sh_n  = {line, sh[7:1]};
                    cnt_n = FULL_LOAD;
                    idx_n = idx + 3'd1;
                    if (idx == 3'd7) state_n = S_STOP;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_STOP: begin
                if (cnt == '0) begin
                    state_n = S_IDLE;
                    if (line) begin
                        push = 1'b1;
                    end else begin
                        ferr_set = 1'b1;
                        armed_n  = 1'b0;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
        // A select change mid-frame silently abandons the frame and waits for idle.
        if (sel_chg && state != S_IDLE) begin
            state_n  = S_IDLE;
            armed_n  = 1'b0;
            push     = 1'b0;
            ferr_set = 1'b0;
        end
    end

`ifdef SERV_UART_RX_FIFO_EN
    logic [7:0] mem [4];
    logic [2:0] wp, rp;
    logic       empty, full, pop;

    assign empty  = (wp == rp);
    assign full   = (wp[2] != rp[2]) && (wp[1:0] == rp[1:0]);
    assign pop    = !empty && i_ready;
    assign accept = push && (!full || pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 4; i++) mem[i] <= 8'd0;
            wp <= 3'd0;
            rp <= 3'd0;
        end else begin
            if (accept) begin
                mem[wp[1:0]] <= sh;
                wp           <= wp + 3'd1;
            end
            if (pop) rp <= rp + 3'd1;
        end
    end

    assign o_data  = mem[rp[1:0]];
    assign o_valid = !empty;
`else
    logic [7:0] data_r;
    logic       valid_r, pop;

    assign pop    = valid_r && i_ready;
    assign accept = push && (!valid_r || pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_r  <= 8'd0;
            valid_r <= 1'b0;
        end else begin
            if (accept) data_r <= sh;
            valid_r <= accept || (valid_r && !pop);
        end
    end

    assign o_data  = data_r;
    assign o_valid = valid_r;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ferr    <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_ferr    <= ferr_set;
            o_overrun <= push && !accept;
        end
    end

endmodule

// File: tb/tb_serv_uart_rx_mux.sv
// tb/tb_serv_uart_rx_mux.sv - scoreboard bench for serv_uart_rx_mux with random bytes and channels
module tb_serv_uart_rx_mux;

    localparam int NUM = 6;
    localparam int CPB = 8;
`ifdef SERV_UART_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NUM-1:0] q   = '1;
    logic [2:0]     sel = 3'd2;
    logic           ready = 1'b1;
    logic [7:0]     data;
    logic           valid, ferr, ovr;

    int checks = 0, failures = 0;
    int ferr_cnt = 0, ovr_cnt = 0, exp_ferr = 0, exp_ovr = 0;
    int cyc = 0, t_valid = -1;
    logic prev_valid = 1'b0;
    logic [7:0] exp_q[$];

    serv_uart_rx_mux #(.NUM(NUM), .CLKS_PER_BIT(CPB)) dut (
        .i_clk(clk), .i_rst(rst), .i_q(q), .i_sel(sel),
        .o_data(data), .o_valid(valid), .i_ready(ready),
        .o_ferr(ferr), .o_overrun(ovr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented byte is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (ferr) ferr_cnt++;
            if (ovr) ovr_cnt++;
            if (valid && !prev_valid) t_valid = cyc;
            prev_valid = valid;
            if (valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", int'(data), -1);
                end else begin
                    check("byte", int'(data), int'(exp_q[0]));
                    if (ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            q[ch] = bits[i];
            tick(CPB);
        end
        q[ch] = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 1000) begin
            tick(1);
            n++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_ferr_cnt"}, ferr_cnt, exp_ferr);
        check({tag, "_ovr_cnt"}, ovr_cnt, exp_ovr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, occ, s, ch;
        logic [7:0] b;

        #12;
        check("rst_valid", int'(valid), 0);
        check("rst_data", int'(data), 0);
        check("rst_ferr", int'(ferr), 0);
        check("rst_ovr", int'(ovr), 0);
        tick(2);
        rst = 1'b0;

        tick(40);
        check_counts("idle");

        // Single byte with exact latency from the raw start edge.
        t_valid = -1;
        exp_q.push_back(8'hA5);
        start = cyc;
        send(2, 8'hA5, 1'b1);
        tick(4);
        check("latency", t_valid - start, 2 + CPB / 2 + 9 * CPB + 1);
        drain();

        // Framing error, then recovery after one idle bit time.
        exp_ferr++;
        send(2, 8'h3C, 1'b0);
        tick(CPB);
        exp_q.push_back(8'h55);
        send(2, 8'h55, 1'b1);
        drain();
        check_counts("ferr");

        // Channel switch during bit 3 of a channel 1 frame.
        sel = 3'd1;
        tick(5);
        fork
            send(1, 8'hFF, 1'b1);
            begin
                tick(4 * CPB + 3);
                sel = 3'd4;
            end
        join
        tick(CPB);
        exp_q.push_back(8'h12);
        send(4, 8'h12, 1'b1);
        drain();
        check_counts("switch");

        // Overrun: consumer stalled, five back-to-back frames.
        sel = 3'd2;
        tick(5);
        ready = 1'b0;
        occ = 0;
        for (int i = 1; i <= 5; i++) begin
            if (occ < CAP) begin
                exp_q.push_back(8'(i));
                occ++;
            end else begin
                exp_ovr++;
            end
            send(2, 8'(i), 1'b1);
        end
        tick(10);
        check_counts("overrun");
        check("held_valid", int'(valid), 1);
        ready = 1'b1;
        drain();

        // Glitch rejection, then out-of-range select maps to channel 0.
        q[2] = 1'b0;
        tick(2);
        q[2] = 1'b1;
        tick(3 * CPB);
        sel = 3'd7;
        tick(5);
        exp_q.push_back(8'h81);
        send(0, 8'h81, 1'b1);
        drain();
        check_counts("glitch");

        // Random bytes on random selects, including out-of-range values.
        for (int r = 0; r < 8; r++) begin
            s = $urandom_range(0, 7);
            ch = (s >= NUM) ? 0 : s;
            sel = 3'(s);
            tick($urandom_range(3, 12));
            b = 8'($urandom);
            exp_q.push_back(b);
            send(ch, b, 1'b1);
        end
        drain();
        check_counts("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
